hue_fade_pwm: RTL and testbench
===============================

Name: hue_fade_pwm

Overview:
- Smooth-fade successor stage to the LED colour sequencer. It replaces hard on/off toggling with a continuous hue wheel, red→yellow→green→cyan→blue→magenta→red.
- Generates three 8-bit channel levels from a stepped hue position.
- Drives the active-low RGB LED pins directly through per-channel PWM.
- Sits between the board clock and the top-level RGB_R/RGB_G/RGB_B pins.

Parameters:
- STEP_INTERVAL, 46875: enabled clocks per hue step. Must be ≥1. Full wheel period = 6*256*STEP_INTERVAL clocks (≈6 s at 12 MHz).
- PWM_BITS, 8: PWM counter and duty width. Fixed at 8 in this revision; the level arithmetic assumes 255 full scale.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  hue advance enable; PWM keeps running when low.
- RGB_R  output  1  red LED pin, active-low (0 = lit).
- RGB_G  output  1  green LED pin, active-low.
- RGB_B  output  1  blue LED pin, active-low.
- r_duty  output  8  currently applied red duty.
- g_duty  output  8  currently applied green duty.
- b_duty  output  8  currently applied blue duty.
- hue_seg  output  3  current segment, 0..5.
- cycle_done  output  1  one-clock pulse on wheel wrap.

Behaviour:
- Reset is asynchronous and active-high. On assertion:
  - prescaler=0, hue_seg=0, ramp=0, pwm_cnt=0.
  - r/g/b_duty=0.
  - RGB_R/G/B=1 (all off).
  - cycle_done=0.
- Reset asserted mid-operation forces the same state immediately, without waiting for a clock edge.
- Prescaler:
  - Counts 0..STEP_INTERVAL-1, but only while en=1.
  - The terminal count (prescaler==STEP_INTERVAL-1 with en=1) generates step, and the prescaler returns to 0.
  - en=0 holds the prescaler, ramp and hue_seg.
- Hue position on step:
  - ramp increments.
  - When ramp goes 255→0, hue_seg increments.
  - When hue_seg goes 5→0 on that same step, cycle_done=1 for exactly that one clock.
- With STEP_INTERVAL=1, a step occurs on every enabled clock.
- Level map (combinational from hue_seg/ramp):
  - seg0: R=255, G=ramp, B=0
  - seg1: R=255-ramp, G=255, B=0
  - seg2: R=0, G=255, B=ramp
  - seg3: R=0, G=255-ramp, B=255
  - seg4: R=ramp, G=0, B=255
  - seg5: R=255, G=0, B=255-ramp
  - hue_seg values 6..7 are unreachable; treat them as seg0.
- PWM counter:
  - pwm_cnt free-runs 0..255 every clock, independent of en, and wraps to 0.
- Duty latch:
  - When pwm_cnt==255, each *_duty loads its current combinational level, effective from the next clock (pwm_cnt=0).
  - This prevents mid-period duty glitches.
  - Hue steps within a PWM period are visible only at the next boundary.
- Pin output, registered with one-clock latency:
  - RGB_x <= ~(pwm_cnt < x_duty).
  - Duty 0 means never lit; duty 255 means lit 255 of every 256 clocks.
- After reset:
  - The first duty load happens on the clock where pwm_cnt==255, i.e. the 256th edge after reset release.
  - r_duty becomes 255 at that point; g_duty and b_duty stay 0.
- Simultaneous events:
  - step and the duty load on the same clock: the load uses the pre-step level.
  - A wrap and a step on the same clock are handled within the single cycle_done pulse.

Decomposition:
- Package rgb_fade_pkg holds:
  - segment enum seg_t: SEG_R_Y, SEG_Y_G, SEG_G_C, SEG_C_B, SEG_B_M, SEG_M_R.
  - constants NUM_SEGS=6 and LEVEL_MAX=255.
  - typedef level_t as logic [7:0].
- Sub-module pwm_channel, instantiated three times. It contains:
  - the duty latch on the load strobe;
  - the comparator against the shared pwm_cnt;
  - the registered active-low pin.
- The top level owns the prescaler, hue state, level map and shared pwm_cnt.

Test Plan:
- Reset state: assert rst asynchronously, no clock edge → RGB_R/G/B=1, duties=0, hue_seg=0, cycle_done=0. Release and run 256 clocks → r_duty=255, g_duty=0, b_duty=0. Afterwards RGB_R is low for exactly 255 of each 256 clocks; RGB_G and RGB_B stay 1.
- Segment boundary (STEP_INTERVAL=2, en=1): after 512 enabled clocks → hue_seg=1. Next duty load gives r_duty≈255-ramp, g_duty=255, b_duty=0.
- Wheel wrap (STEP_INTERVAL=2): cycle_done pulses exactly once, 3072 clocks after reset release. hue_seg returns to 0; the pulse is repeated every 3072 clocks.
- Enable hold: drop en for 1000 clocks mid-seg2 → hue_seg, ramp and duties remain constant; PWM pins keep toggling. On raising en, stepping resumes from the held value.
- Mid-operation reset: assert rst in seg4 while a pin is low → all pins 1 and all state 0 immediately. Post-release behaviour is identical to the first scenario.
- STEP_INTERVAL=1 edge case: ramp increments every enabled clock; cycle_done period = 1536 clocks. The duty latched at each pwm_cnt==255 equals the pre-step level.

Source files
------------

// File: rtl/hue_fade_pwm_pkg.sv
// Shared types and constants for the hue fade PWM stage.
//   seg_t   : hue wheel segment, red->yellow->green->cyan->blue->magenta
//   level_t : 8-bit channel level / PWM duty
//   rgb_t   : packed triple of channel levels
package rgb_fade_pkg;

   localparam int unsigned NUM_SEGS  = 6;
   localparam int unsigned LEVEL_MAX = 255;

   typedef logic [7:0] level_t;

   typedef enum logic [2:0] {
      SEG_R_Y = 3'd0,
      SEG_Y_G = 3'd1,
      SEG_G_C = 3'd2,
      SEG_C_B = 3'd3,
      SEG_B_M = 3'd4,
      SEG_M_R = 3'd5
   } seg_t;

   typedef struct packed {
      level_t r;
      level_t g;
      level_t b;
   } rgb_t;

endpackage

// File: rtl/hue_fade_pwm_if.sv
// Signal bundle between the hue fade PWM stage and its surroundings.
//   en              : hue advance enable (into the stage)
//   RGB_R/G/B       : active-low LED pins
//   r/g/b_duty      : duties currently applied to the pins
//   hue_seg         : current wheel segment 0..5
//   cycle_done      : one-clock pulse when the wheel wraps
// master = the driver of en and observer of outputs; slave = the stage itself.
interface hue_fade_pwm_if
   import rgb_fade_pkg::*;
   ;

   logic       en;
   logic       RGB_R;
   logic       RGB_G;
   logic       RGB_B;
   level_t     r_duty;
   level_t     g_duty;
   level_t     b_duty;
   logic [2:0] hue_seg;
   logic       cycle_done;

   modport master (
      output en,
      input  RGB_R, RGB_G, RGB_B,
      input  r_duty, g_duty, b_duty,
      input  hue_seg, cycle_done
   );

   modport slave (
      input  en,
      output RGB_R, RGB_G, RGB_B,
      output r_duty, g_duty, b_duty,
      output hue_seg, cycle_done
   );

endinterface

// File: rtl/hue_fade_pwm_pwm_channel.sv
// One PWM output channel.
//   clk, rst : clock and asynchronous active-high reset
//   load     : duty latch strobe (asserted on the last count of a PWM period)
//   level    : level to latch into the duty register on load
//   pwm_cnt  : shared free-running PWM counter
//   duty     : currently applied duty
//   pin      : registered active-low LED pin, lit while pwm_cnt < duty
module pwm_channel
   import rgb_fade_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  level_t level,
   input  level_t pwm_cnt,
   output level_t duty,
   output logic   pin
);

   level_t duty_q;
   logic   pin_q;

   // The duty only changes at a period boundary so a period is never split
   // between two different duties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_q <= '0;
         pin_q  <= 1'b1;
      end else begin
         if (load) begin
            duty_q <= level;
         end
         pin_q <= ~(pwm_cnt < duty_q);
      end
   end

   assign duty = duty_q;
   assign pin  = pin_q;

endmodule

// File: rtl/hue_fade_pwm.sv
// Continuous hue wheel driving an active-low RGB LED through per-channel PWM.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of hue_fade_pwm_if (en in; pins, duties, hue_seg,
//          cycle_done out)
// A prescaler divides enabled clocks into hue steps; each step advances an
// 8-bit ramp within one of six segments. The level map turns segment/ramp
// into three channel levels that the PWM channels latch once per period.
module hue_fade_pwm
   import rgb_fade_pkg::*;
#(
   parameter int unsigned STEP_INTERVAL = 46875,
   parameter int unsigned PWM_BITS      = 8
) (
   input logic           clk,
   input logic           rst,
   hue_fade_pwm_if.slave bus
);

   // Keep at least one bit so STEP_INTERVAL=1 still has a (constant-0) counter.
   localparam int unsigned PRE_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_INTERVAL - 1);
   localparam level_t LVL_MAX = level_t'(LEVEL_MAX);

   logic [PRE_W-1:0]    pre_q, pre_d;
   level_t              ramp_q, ramp_d;
   seg_t                seg_q, seg_d;
   logic                done_q, done_d;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic                step;
   logic                duty_load;
   rgb_t                lvl;

   // ---------------------------------------------------------------------
   // Hue state: prescaler, ramp, segment, wrap pulse
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q  <= '0;
         ramp_q <= '0;
         seg_q  <= SEG_R_Y;
         done_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         ramp_q <= ramp_d;
         seg_q  <= seg_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      step   = bus.en && (pre_q == PRE_LAST);
      pre_d  = pre_q;
      ramp_d = ramp_q;
      seg_d  = seg_q;
      done_d = 1'b0;

      if (bus.en) begin
         pre_d = step ? '0 : pre_q + 1'b1;
      end

      if (step) begin
         ramp_d = ramp_q + 1'b1;
         if (ramp_q == LVL_MAX) begin
            if (seg_q == SEG_M_R) begin
               seg_d  = SEG_R_Y;
               done_d = 1'b1;
            end else begin
               seg_d = seg_t'(seg_q + 3'd1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Level map; 6 and 7 cannot occur but fall back to the first segment.
   // ---------------------------------------------------------------------
   always_comb begin
      lvl = '0;
      case (seg_q)
         SEG_Y_G: begin
            lvl.r = LVL_MAX - ramp_q;
            lvl.g = LVL_MAX;
            lvl.b = '0;
         end
         SEG_G_C: begin
            lvl.r = '0;
            lvl.g = LVL_MAX;
            lvl.b = ramp_q;
         end
         SEG_C_B: begin
            lvl.r = '0;
            lvl.g = LVL_MAX - ramp_q;
            lvl.b = LVL_MAX;
         end
         SEG_B_M: begin
            lvl.r = ramp_q;
            lvl.g = '0;
            lvl.b = LVL_MAX;
         end
         SEG_M_R: begin
            lvl.r = LVL_MAX;
            lvl.g = '0;
            lvl.b = LVL_MAX - ramp_q;
         end
         default: begin
            lvl.r = LVL_MAX;
            lvl.g = ramp_q;
            lvl.b = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Shared PWM counter, free-running regardless of en
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end
   end

   // Loading on the last count makes the new duty effective from count 0.
   // The level used is the one before any step taken on this same edge.
   assign duty_load = &pwm_cnt_q;

   level_t r_duty, g_duty, b_duty;
   logic   r_pin, g_pin, b_pin;

   pwm_channel u_red (
      .clk     (clk),
      .rst     (rst),
      .load    (duty_load),
      .level   (lvl.r),
      .pwm_cnt (pwm_cnt_q),
      .duty    (r_duty),
      .pin     (r_pin)
   );

   pwm_channel u_green (
      .clk     (clk),
      .rst     (rst),
      .load    (duty_load),
      .level   (lvl.g),
      .pwm_cnt (pwm_cnt_q),
      .duty    (g_duty),
      .pin     (g_pin)
   );

   pwm_channel u_blue (
      .clk     (clk),
      .rst     (rst),
      .load    (duty_load),
      .level   (lvl.b),
      .pwm_cnt (pwm_cnt_q),
      .duty    (b_duty),
      .pin     (b_pin)
   );

   assign bus.RGB_R      = r_pin;
   assign bus.RGB_G      = g_pin;
   assign bus.RGB_B      = b_pin;
   assign bus.r_duty     = r_duty;
   assign bus.g_duty     = g_duty;
   assign bus.b_duty     = b_duty;
   assign bus.hue_seg    = seg_q;
   assign bus.cycle_done = done_q;

endmodule

// File: tb/tb_hue_fade_pwm.sv
// Bench for hue_fade_pwm: two instances (STEP_INTERVAL 2 and 1) share clock,
// reset and a random enable; each is compared every clock against a model
// that derives all outputs from counts of elapsed clocks and enabled clocks.
module tb_hue_fade_pwm;

   logic clk;
   logic rst;
   logic en;

   hue_fade_pwm_if if_a ();
   hue_fade_pwm_if if_b ();

   assign if_a.en = en;
   assign if_b.en = en;

   hue_fade_pwm #(.STEP_INTERVAL(2), .PWM_BITS(8)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a)
   );

   hue_fade_pwm #(.STEP_INTERVAL(1), .PWM_BITS(8)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;

   // Model state per instance: clocks since release, enabled clocks since
   // release, applied duties, pin levels and the wrap pulse.
   int m_clk [2];
   int m_en  [2];
   int m_duty[2][3];
   int m_pin [2][3];
   int m_cd  [2];

   task automatic check_val(input string tag, input logic [31:0] got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int si_of(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   // Hue wheel: channel level from a total step count.
   function automatic int ref_level(input int ch, input int steps);
      int ramp, seg, up, dn;
      ramp = steps % 256;
      seg  = (steps / 256) % 6;
      up   = ramp;
      dn   = 255 - ramp;
      case (ch)
         0: case (seg) 0: return 255; 1: return dn; 2: return 0;
                       3: return 0; 4: return up; default: return 255; endcase
         1: case (seg) 0: return up; 1: return 255; 2: return 255;
                       3: return dn; 4: return 0; default: return 0; endcase
         default: case (seg) 0: return 0; 1: return 0; 2: return up;
                       3: return 255; 4: return 255; default: return dn; endcase
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_clk[d] = 0;
         m_en[d]  = 0;
         m_cd[d]  = 0;
         for (int c = 0; c < 3; c++) begin
            m_duty[d][c] = 0;
            m_pin[d][c]  = 1;
         end
      end
   endtask

   task automatic model_edge(input int d);
      int pre_cnt, pre_steps, post_steps;
      pre_cnt   = m_clk[d] % 256;
      pre_steps = m_en[d] / si_of(d);
      for (int c = 0; c < 3; c++) begin
         m_pin[d][c] = (pre_cnt < m_duty[d][c]) ? 0 : 1;
         if (pre_cnt == 255) m_duty[d][c] = ref_level(c, pre_steps);
      end
      m_cd[d] = 0;
      if (en) begin
         m_en[d]++;
         post_steps = m_en[d] / si_of(d);
         if (post_steps != pre_steps && post_steps % 1536 == 0) m_cd[d] = 1;
      end
      m_clk[d]++;
   endtask

   task automatic check_dut(input int d, input logic [7:0] rd, input logic [7:0] gd,
                            input logic [7:0] bd, input logic [2:0] seg, input logic pr,
                            input logic pg, input logic pb, input logic cd);
      string p;
      p = (d == 0) ? "si2" : "si1";
      check_val({p, " r_duty"}, 32'(rd), m_duty[d][0]);
      check_val({p, " g_duty"}, 32'(gd), m_duty[d][1]);
      check_val({p, " b_duty"}, 32'(bd), m_duty[d][2]);
      check_val({p, " hue_seg"}, 32'(seg), ((m_en[d] / si_of(d)) / 256) % 6);
      check_val({p, " RGB_R"}, 32'(pr), m_pin[d][0]);
      check_val({p, " RGB_G"}, 32'(pg), m_pin[d][1]);
      check_val({p, " RGB_B"}, 32'(pb), m_pin[d][2]);
      check_val({p, " cycle_done"}, 32'(cd), m_cd[d]);
   endtask

   task automatic check_all();
      check_dut(0, if_a.r_duty, if_a.g_duty, if_a.b_duty, if_a.hue_seg,
                if_a.RGB_R, if_a.RGB_G, if_a.RGB_B, if_a.cycle_done);
      check_dut(1, if_b.r_duty, if_b.g_duty, if_b.b_duty, if_b.hue_seg,
                if_b.RGB_R, if_b.RGB_G, if_b.RGB_B, if_b.cycle_done);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         model_edge(0);
         model_edge(1);
      end
      #1;
      check_all();
   endtask

   int cd_a;
   int cd_b;

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      model_reset();
      #2;
      // Reset state before any clock edge.
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // Random enable, then a long hold, then steady enable.
      repeat (1300) begin
         en = ($urandom_range(0, 9) != 0);
         tick();
      end
      en = 1'b0;
      repeat (1000) tick();
      en = 1'b1;
      for (int i = 0; i < 3000 && m_en[0] < 2300; i++) tick();

      // Asynchronous reset between edges, checked before any edge.
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;

      // Steady enable from release: wrap counts are fixed by the step intervals.
      en   = 1'b1;
      cd_a = 0;
      cd_b = 0;
      repeat (3200) begin
         tick();
         cd_a += int'(if_a.cycle_done);
         cd_b += int'(if_b.cycle_done);
      end
      check_val("si2 wraps in 3200", 32'(cd_a), 1);
      check_val("si1 wraps in 3200", 32'(cd_b), 2);

      repeat (500) begin
         en = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
